// File: rtl/m_clk_div_pkg.sv
// Shared types and defaults for the glitch-free programmable clock divider.
package m_clk_div_pkg;

    localparam int unsigned DIV_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/m_clk_div.sv
// Programmable glitch-free clock divider with polarity select; config changes
// are staged in a shadow register and applied only at period boundaries.
module m_clk_div
    import m_clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_half,
    input  logic             cfg_inv,
    output logic             div_clk,
    output logic             inv_sel,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             running
);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   half_q, half_d;
    logic               div_q, div_d;
    logic               inv_q, inv_d;
    logic [DIV_W-1:0]   pend_half_q, pend_half_d;
    logic               pend_inv_q, pend_inv_d;
    logic               pend_v_q, pend_v_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               xfer;
    logic               boundary;
    logic               xclk_q, xclk_d;

    assign xfer     = cfg_valid && !pend_v_q;
    assign boundary = (cnt_q == half_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        div_d       = div_q;
        inv_d       = inv_q;
        pend_half_d = pend_half_q;
        pend_inv_d  = pend_inv_q;
        pend_v_d    = pend_v_q;

        unique case (state_q)
            StIdle: begin
                div_d = 1'b0;
                cnt_d = '0;
                if (pend_v_q) begin
                    half_d   = pend_half_q;
                    inv_d    = pend_inv_q;
                    pend_v_d = 1'b0;
                end
                if (en) begin
                    state_d = StRun;
                    div_d   = 1'b1;
                end
            end
            StRun, StDrain: begin
                if (state_q == StRun && !en) begin
                    state_d = StDrain;
                end else if (state_q == StDrain && en) begin
                    state_d = StRun;
                end

                if (!boundary) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end else begin
                    cnt_d = '0;
                    if (div_q) begin
                        div_d = 1'b0;
                    end else if (state_q == StDrain && !en) begin
                        // Low phase already complete: stop without a new edge.
                        state_d = StIdle;
                    end else if (pend_v_q) begin
                        half_d   = pend_half_q;
                        pend_v_d = 1'b0;
                        // A polarity flip supplies this edge instead of div_clk.
                        if (pend_inv_q != inv_q) begin
                            inv_d = pend_inv_q;
                        end else begin
                            div_d = 1'b1;
                        end
                    end else begin
                        div_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Transfers only happen while the shadow is empty, so they never race an apply.
        if (xfer) begin
            pend_half_d = cfg_half;
            pend_inv_d  = cfg_inv;
            pend_v_d    = 1'b1;
        end
    end

    assign xclk_q = div_q ^ inv_q;
    assign xclk_d = div_d ^ inv_d;
    assign rise_d = xclk_d & ~xclk_q;
    assign fall_d = ~xclk_d & xclk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            half_q      <= '0;
            div_q       <= 1'b0;
            inv_q       <= 1'b0;
            pend_half_q <= '0;
            pend_inv_q  <= 1'b0;
            pend_v_q    <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            div_q       <= div_d;
            inv_q       <= inv_d;
            pend_half_q <= pend_half_d;
            pend_inv_q  <= pend_inv_d;
            pend_v_q    <= pend_v_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    assign cfg_ready = !pend_v_q;
    assign div_clk   = div_q;
    assign inv_sel   = inv_q;
    assign rise_stb  = rise_q;
    assign fall_stb  = fall_q;
    assign running   = (state_q != StIdle);

endmodule

// File: tb/tb_m_clk_div.sv
// Directed self-checking bench for m_clk_div with hand-computed cycle patterns.
module tb_m_clk_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_half;
    logic       cfg_inv;
    logic       div_clk;
    logic       inv_sel;
    logic       rise_stb;
    logic       fall_stb;
    logic       running;

    int checks = 0;
    int errors = 0;

    m_clk_div #(.DIV_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_half  (cfg_half),
        .cfg_inv   (cfg_inv),
        .div_clk   (div_clk),
        .inv_sel   (inv_sel),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = 8'd0;
        cfg_inv   = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Load a config from IDLE and start; returns on the first RUN cycle (div_clk just rose).
    task automatic start_run(input logic [7:0] half, input logic inv);
        cfg_valid = 1'b1;
        cfg_half  = half;
        cfg_inv   = inv;
        step();
        cfg_valid = 1'b0;
        step();
        en = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = 8'd0;
        cfg_inv   = 1'b0;
        step();
        checks += 6;
        if (div_clk !== 1'b0) begin errors++; $display("FAIL reset div_clk got %b exp 0", div_clk); end
        if (inv_sel !== 1'b0) begin errors++; $display("FAIL reset inv_sel got %b exp 0", inv_sel); end
        if (rise_stb !== 1'b0) begin errors++; $display("FAIL reset rise_stb got %b exp 0", rise_stb); end
        if (fall_stb !== 1'b0) begin errors++; $display("FAIL reset fall_stb got %b exp 0", fall_stb); end
        if (running !== 1'b0) begin errors++; $display("FAIL reset running got %b exp 0", running); end
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset cfg_ready got %b exp 1", cfg_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_start();
        logic [11:0] exp_div  = 12'b111000111000;
        logic [11:0] exp_rise = 12'b100000100000;
        logic [11:0] exp_fall = 12'b000100000100;
        do_reset();
        cfg_valid = 1'b1;
        cfg_half  = 8'd2;
        cfg_inv   = 1'b0;
        step();
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL start ready_after_xfer got %b exp 0", cfg_ready); end
        cfg_valid = 1'b0;
        step();
        checks += 2;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL start ready_after_apply got %b exp 1", cfg_ready); end
        if (div_clk !== 1'b0) begin errors++; $display("FAIL start idle_div got %b exp 0", div_clk); end
        en = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            checks += 4;
            if (div_clk !== exp_div[11-i]) begin
                errors++; $display("FAIL start div_clk idx %0d got %b exp %b", i, div_clk, exp_div[11-i]);
            end
            if (rise_stb !== exp_rise[11-i]) begin
                errors++; $display("FAIL start rise_stb idx %0d got %b exp %b", i, rise_stb, exp_rise[11-i]);
            end
            if (fall_stb !== exp_fall[11-i]) begin
                errors++; $display("FAIL start fall_stb idx %0d got %b exp %b", i, fall_stb, exp_fall[11-i]);
            end
            if (running !== 1'b1) begin
                errors++; $display("FAIL start running idx %0d got %b exp 1", i, running);
            end
            step();
        end
    endtask

    task automatic test_ratio_change();
        logic [11:0] exp_div = 12'b111000101010;
        logic [11:0] exp_rdy = 12'b100000111111;
        do_reset();
        start_run(8'd2, 1'b0);
        for (int i = 0; i < 12; i++) begin
            checks += 2;
            if (div_clk !== exp_div[11-i]) begin
                errors++; $display("FAIL ratio div_clk idx %0d got %b exp %b", i, div_clk, exp_div[11-i]);
            end
            if (cfg_ready !== exp_rdy[11-i]) begin
                errors++; $display("FAIL ratio cfg_ready idx %0d got %b exp %b", i, cfg_ready, exp_rdy[11-i]);
            end
            if (i == 0) begin
                cfg_valid = 1'b1;
                cfg_half  = 8'd0;
                cfg_inv   = 1'b0;
            end else if (i == 1) begin
                cfg_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_polarity();
        logic [13:0] exp_xclk = 14'b11100011100011;
        logic [13:0] exp_inv  = 14'b00000011111111;
        logic [13:0] exp_rise = 14'b10000010000010;
        logic [13:0] exp_fall = 14'b00010000010000;
        do_reset();
        start_run(8'd2, 1'b0);
        for (int i = 0; i < 14; i++) begin
            checks += 4;
            if ((div_clk ^ inv_sel) !== exp_xclk[13-i]) begin
                errors++; $display("FAIL polarity xclk idx %0d got %b exp %b", i, div_clk ^ inv_sel, exp_xclk[13-i]);
            end
            if (inv_sel !== exp_inv[13-i]) begin
                errors++; $display("FAIL polarity inv_sel idx %0d got %b exp %b", i, inv_sel, exp_inv[13-i]);
            end
            if (rise_stb !== exp_rise[13-i]) begin
                errors++; $display("FAIL polarity rise_stb idx %0d got %b exp %b", i, rise_stb, exp_rise[13-i]);
            end
            if (fall_stb !== exp_fall[13-i]) begin
                errors++; $display("FAIL polarity fall_stb idx %0d got %b exp %b", i, fall_stb, exp_fall[13-i]);
            end
            if (i == 0) begin
                cfg_valid = 1'b1;
                cfg_half  = 8'd2;
                cfg_inv   = 1'b1;
            end else if (i == 1) begin
                cfg_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_stop_restart();
        logic [7:0] exp_div  = 8'b11100000;
        logic [7:0] exp_run  = 8'b11111100;
        logic [9:0] exp_div2 = 10'b1110001110;
        do_reset();
        start_run(8'd2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks += 2;
            if (div_clk !== exp_div[7-i]) begin
                errors++; $display("FAIL stop div_clk idx %0d got %b exp %b", i, div_clk, exp_div[7-i]);
            end
            if (running !== exp_run[7-i]) begin
                errors++; $display("FAIL stop running idx %0d got %b exp %b", i, running, exp_run[7-i]);
            end
            if (i == 1) en = 1'b0;
            step();
        end
        en = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            checks += 2;
            if (div_clk !== exp_div2[9-i]) begin
                errors++; $display("FAIL resume div_clk idx %0d got %b exp %b", i, div_clk, exp_div2[9-i]);
            end
            if (running !== 1'b1) begin
                errors++; $display("FAIL resume running idx %0d got %b exp 1", i, running);
            end
            if (i == 1) en = 1'b0;
            else if (i == 2) en = 1'b1;
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp_div = 14'b11100011001010;
        logic [13:0] exp_rdy = 14'b10000010001111;
        do_reset();
        start_run(8'd2, 1'b0);
        for (int i = 0; i < 14; i++) begin
            checks += 2;
            if (div_clk !== exp_div[13-i]) begin
                errors++; $display("FAIL b2b div_clk idx %0d got %b exp %b", i, div_clk, exp_div[13-i]);
            end
            if (cfg_ready !== exp_rdy[13-i]) begin
                errors++; $display("FAIL b2b cfg_ready idx %0d got %b exp %b", i, cfg_ready, exp_rdy[13-i]);
            end
            if (i == 0) begin
                cfg_valid = 1'b1;
                cfg_half  = 8'd1;
                cfg_inv   = 1'b0;
            end else if (i == 1) begin
                cfg_half = 8'd0;
            end else if (i == 7) begin
                cfg_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_max_ratio();
        int n;
        do_reset();
        start_run(8'd255, 1'b0);
        n = 0;
        while (div_clk === 1'b1 && n < 600) begin
            n++;
            step();
        end
        checks++;
        if (n != 256) begin errors++; $display("FAIL max_ratio high_len got %0d exp 256", n); end
        n = 0;
        while (div_clk === 1'b0 && n < 600) begin
            n++;
            step();
        end
        checks++;
        if (n != 256) begin errors++; $display("FAIL max_ratio low_len got %0d exp 256", n); end
    endtask

    task automatic test_async_reset();
        logic [5:0] exp_div = 6'b111000;
        do_reset();
        start_run(8'd2, 1'b0);
        step();
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (div_clk !== 1'b0) begin errors++; $display("FAIL arst div_clk got %b exp 0", div_clk); end
        if (rise_stb !== 1'b0) begin errors++; $display("FAIL arst rise_stb got %b exp 0", rise_stb); end
        if (fall_stb !== 1'b0) begin errors++; $display("FAIL arst fall_stb got %b exp 0", fall_stb); end
        if (running !== 1'b0) begin errors++; $display("FAIL arst running got %b exp 0", running); end
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL arst cfg_ready got %b exp 1", cfg_ready); end
        en = 1'b0;
        step();
        rst = 1'b0;
        step();
        start_run(8'd2, 1'b0);
        checks++;
        if (rise_stb !== 1'b1) begin errors++; $display("FAIL arst restart_rise got %b exp 1", rise_stb); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (div_clk !== exp_div[5-i]) begin
                errors++; $display("FAIL arst restart div_clk idx %0d got %b exp %b", i, div_clk, exp_div[5-i]);
            end
            step();
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = 8'd0;
        cfg_inv   = 1'b0;
        test_reset();
        test_start();
        test_ratio_change();
        test_polarity();
        test_stop_restart();
        test_back_to_back();
        test_max_ratio();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
